// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer with flush.
// Define INST_QUEUE_BYPASS_EN to let an entry pass through an empty queue in the same cycle.
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp_reg, wp_next;
  logic [PTR_W-1:0]  rp_reg, rp_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              empty;
  logic              bypass_take;
  logic              push_en;
  logic              pop_en;

  assign empty    = (count_reg == '0);
  // Depends only on stored occupancy, never on out_ready.
  assign in_ready = (count_reg != CNT_W'(DEPTH));
  assign count    = count_reg;

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue with a ready consumer: the entry flows straight through, nothing is stored.
  assign bypass_take = empty & in_valid & out_ready & ~flush;
  assign out_valid   = empty ? (in_valid & ~flush) : ~flush;
  assign out_data    = empty ? in_data : mem[rp_reg];
`else
  assign bypass_take = 1'b0;
  assign out_valid   = ~empty & ~flush;
  assign out_data    = mem[rp_reg];
`endif

  assign push_en = in_valid & in_ready & ~flush & ~bypass_take;
  assign pop_en  = out_valid & out_ready & ~flush & ~empty;

  always_comb begin
    wp_next    = wp_reg;
    rp_next    = rp_reg;
    count_next = count_reg;
    if (flush) begin
      wp_next    = '0;
      rp_next    = '0;
      count_next = '0;
    end else begin
      if (push_en) wp_next = wp_reg + PTR_W'(1);
      if (pop_en)  rp_next = rp_reg + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      wp_reg    <= wp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_en && (wp_reg == PTR_W'(gi))) mem[gi] <= in_data;
      end
    end
  endgenerate

endmodule
